// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multicycle instruction sequencer for the MIPS core. Steps the control
//   decoder through FETCH -> EXEC1 -> EXEC2 for every instruction, holds the
//   current state while memory asserts waitrequest, and halts the core after a
//   jump to address 0 once that jump's branch delay slot has executed.
//   Free-running cycle and retired-instruction counters are also kept.
//
// Ports
//   clk_i           in   core clock, all state on rising edge
//   rst_n_i         in   asynchronous active-low reset
//   mem_req_i       in   control drives a RAM read/write this cycle
//   waitrequest_i   in   memory not ready, access must be held
//   pc_next_zero_i  in   PC target written in this EXEC2 is 0x00000000
//   state_o         out  sequencer state: 0=FETCH 1=EXEC1 2=EXEC2 3=HALT
//   active_o        out  core running (low in reset and once halted)
//   stall_o         out  memory stall this cycle (combinational)
//   instr_retired_o out  pulse in the EXEC2 cycle that advances (combinational)
//   delay_slot_o    out  current instruction is the delay slot of a jump-to-0
//   cycle_count_o   out  active cycles including stalls, wraps
//   instr_count_o   out  retired instructions, wraps
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               mem_req_i,
    input  logic               waitrequest_i,
    input  logic               pc_next_zero_i,
    output logic [1:0]         state_o,
    output logic               active_o,
    output logic               stall_o,
    output logic               instr_retired_o,
    output logic               delay_slot_o,
    output logic [COUNT_W-1:0] cycle_count_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC1 = 2'd1,
        ST_EXEC2 = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};

    state_t             state_r;
    logic               active_r;
    logic               delay_slot_r;
    logic [COUNT_W-1:0] cycle_count_r;
    logic [COUNT_W-1:0] instr_count_r;

    logic               running_s;
    logic               stall_s;
    logic               advance_s;
    logic               retire_s;

    // running_s is false in reset, during the warm-up cycle and in HALT, which
    // gates stall, retire and the cycle counter in one place.
    assign running_s = active_r & (state_r != ST_HALT);
    assign stall_s   = running_s & mem_req_i & waitrequest_i;
    assign advance_s = running_s & ~stall_s;
    assign retire_s  = advance_s & (state_r == ST_EXEC2);

    // Sequencer state, halt tracking and counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r       <= ST_FETCH;
            active_r      <= 1'b0;
            delay_slot_r  <= 1'b0;
            cycle_count_r <= CNT_ZERO;
            instr_count_r <= CNT_ZERO;
        end else begin
            if (!active_r) begin
                // Warm-up edge: go active without moving out of FETCH.
                // Once halted, active stays low until the next reset.
                active_r <= (state_r != ST_HALT);
            end else if (advance_s) begin
                case (state_r)
                    ST_FETCH: state_r <= ST_EXEC1;
                    ST_EXEC1: state_r <= ST_EXEC2;
                    ST_EXEC2: begin
                        if (delay_slot_r) begin
                            // Delay slot done; its own pc_next_zero is ignored.
                            state_r      <= ST_HALT;
                            delay_slot_r <= 1'b0;
                            active_r     <= 1'b0;
                        end else begin
                            state_r      <= ST_FETCH;
                            delay_slot_r <= pc_next_zero_i;
                        end
                    end
                    default: begin
                        state_r  <= ST_HALT;
                        active_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end

            if (running_s) begin
                cycle_count_r <= cycle_count_r + CNT_ONE;
            end
            if (retire_s) begin
                instr_count_r <= instr_count_r + CNT_ONE;
            end
        end
    end

    assign state_o         = state_r;
    assign active_o        = active_r;
    assign delay_slot_o    = delay_slot_r;
    assign stall_o         = stall_s;
    assign instr_retired_o = retire_s;
    assign cycle_count_o   = cycle_count_r;
    assign instr_count_o   = instr_count_r;

endmodule
